// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer gating pong frame ticks, serves, hit/miss detection, score and lives
module pong_match_ctrl #(
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES = 90,
  parameter int LIVES = 3,
  parameter int MISS_X = 8,
  parameter int PADDLE_H = 64,
  parameter int BALL_H = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       start_btn,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] paddle_y,
  output logic       frame_tick,
  output logic       game_reset,
  output logic [7:0] score,
  output logic [2:0] lives,
  output logic [2:0] state
);
  typedef enum logic [2:0] {ATTRACT = 3'd0, SERVE = 3'd1, PLAY = 3'd2, MISS = 3'd3, OVER = 3'd4} state_t;
  state_t st;
  logic fs_q, fs_qq, btn_q, armed;
  logic [7:0] cnt;
  logic fev, sev, wall, overlap;
  logic [7:0] cnt_inc, score_inc;
  assign fev = fs_q & ~fs_qq;
  assign sev = start_btn & ~btn_q;
  assign wall = ball_x <= 10'(MISS_X);
  assign overlap = ({1'b0, ball_y} + 11'(BALL_H) > {1'b0, paddle_y}) &&
                   ({1'b0, ball_y} < {1'b0, paddle_y} + 11'(PADDLE_H));
  assign cnt_inc = cnt + 8'd1;
  assign score_inc = score == 8'h99 ? score :
                     score[3:0] == 4'd9 ? {score[7:4] + 4'd1, 4'd0} : {score[7:4], score[3:0] + 4'd1};
  assign state = st;
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= ATTRACT;
      score <= 8'h00;
      lives <= 3'd0;
      frame_tick <= 1'b0;
      game_reset <= 1'b1;
      armed <= 1'b0;
      cnt <= 8'd0;
      fs_q <= 1'b0;
      fs_qq <= 1'b0;
      btn_q <= 1'b0;
    end else begin
      fs_q <= frame_start;
      fs_qq <= fs_q;
      btn_q <= start_btn;
      frame_tick <= fev && st == PLAY;
      game_reset <= 1'b0;
      case (st)
        ATTRACT, OVER: if (sev) begin
          st <= SERVE;
          lives <= 3'(LIVES);
          score <= 8'h00;
          cnt <= 8'd0;
          game_reset <= 1'b1;
        end
        SERVE: if (fev) begin
          cnt <= cnt_inc;
          if (cnt_inc == 8'(SERVE_FRAMES)) begin
            st <= PLAY;
            armed <= 1'b1;
          end
        end
        PLAY: if (fev) begin
          if (wall && armed && overlap) begin
            score <= score_inc;
            armed <= 1'b0;
          end else if (wall && armed) begin
            lives <= lives - 3'd1;
            cnt <= 8'd0;
            st <= MISS;
          end else if (!wall) armed <= 1'b1;
        end
        MISS: if (fev) begin
          cnt <= cnt_inc;
          if (cnt_inc == 8'(MISS_FRAMES)) begin
            cnt <= 8'd0;
            st <= lives == 3'd0 ? OVER : SERVE;
            game_reset <= lives != 3'd0;
          end
        end
        default: st <= ATTRACT;
      endcase
    end
  end
endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: directed and randomized check of pong_match_ctrl against an event-level model
module tb_pong_match_ctrl;
  localparam int SF = 2, MF = 2, LV = 2;
  logic clk = 1'b0, reset = 1'b1, frame_start = 1'b0, start_btn = 1'b0;
  logic [9:0] ball_x = 10'd100, ball_y = 10'd200, paddle_y = 10'd180;
  logic frame_tick, game_reset;
  logic [7:0] score;
  logic [2:0] lives, state;
  int n_chk = 0, n_fail = 0;
  int m_st = 0, m_sc = 0, m_lv = 0, m_cnt = 0, m_arm = 0, m_tk = 0, m_gr = 1;
  int m_f1 = 0, m_f2 = 0, m_b = 0;
  pong_match_ctrl #(.SERVE_FRAMES(SF), .MISS_FRAMES(MF), .LIVES(LV)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .start_btn(start_btn),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_y(paddle_y),
    .frame_tick(frame_tick), .game_reset(game_reset), .score(score), .lives(lives), .state(state)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction
  task automatic cyc();
    int fev, sev, wall, ov;
    fev = m_f1 && !m_f2;
    sev = start_btn && !m_b;
    if (reset) begin
      m_st = 0; m_sc = 0; m_lv = 0; m_cnt = 0; m_arm = 0; m_tk = 0; m_gr = 1;
      m_f1 = 0; m_f2 = 0; m_b = 0;
    end else begin
      m_tk = fev && m_st == 2;
      m_gr = 0;
      if ((m_st == 0 || m_st == 4) && sev) begin
        m_st = 1; m_lv = LV; m_sc = 0; m_cnt = 0; m_gr = 1;
      end else if (fev && m_st == 1) begin
        m_cnt++;
        if (m_cnt == SF) begin m_st = 2; m_arm = 1; end
      end else if (fev && m_st == 2) begin
        wall = ball_x <= 8;
        ov = (int'(ball_y) + 8 > int'(paddle_y)) && (int'(ball_y) < int'(paddle_y) + 64);
        if (wall && m_arm && ov) begin
          m_sc = m_sc < 99 ? m_sc + 1 : 99;
          m_arm = 0;
        end else if (wall && m_arm) begin
          m_lv--; m_cnt = 0; m_st = 3;
        end else if (!wall) m_arm = 1;
      end else if (fev && m_st == 3) begin
        m_cnt++;
        if (m_cnt == MF) begin
          m_cnt = 0;
          m_st = m_lv == 0 ? 4 : 1;
          m_gr = m_lv != 0;
        end
      end
      m_f2 = m_f1; m_f1 = frame_start; m_b = start_btn;
    end
    @(posedge clk);
    #1;
    check("state", state, m_st);
    check("score", score, bcd(m_sc));
    check("lives", lives, m_lv);
    check("frame_tick", frame_tick, m_tk);
    check("game_reset", game_reset, m_gr);
  endtask
  task automatic pulse(input int w);
    frame_start = 1'b1;
    repeat (w) cyc();
    frame_start = 1'b0;
    repeat (3) cyc();
  endtask
  task automatic press();
    start_btn = 1'b1;
    cyc();
    start_btn = 1'b0;
    cyc();
  endtask
  task automatic hit();
    ball_x = 10'd100; ball_y = 10'd200; paddle_y = 10'd180;
    pulse(1);
    ball_x = 10'd6;
    pulse(1);
  endtask
  task automatic lose_life();
    ball_x = 10'd100;
    pulse(1);
    ball_x = 10'd6; ball_y = 10'd300; paddle_y = 10'd100;
    pulse(1);
    ball_x = 10'd100;
    pulse(1);
    pulse(1);
  endtask
  initial begin
    int tk_seen;
    repeat (2) cyc();
    check("rst_state", state, 0);
    check("rst_grst", game_reset, 1);
    check("rst_lives", lives, 0);
    reset = 1'b0;
    cyc();
    check("grst_drop", game_reset, 0);
    start_btn = 1'b1;
    cyc();
    check("start_state", state, 1);
    check("start_lives", lives, 2);
    check("start_score", score, 8'h00);
    check("start_grst", game_reset, 1);
    start_btn = 1'b0;
    cyc();
    check("start_grst_1cyc", game_reset, 0);
    tk_seen = 0;
    for (int i = 0; i < 2; i++) begin
      frame_start = 1'b1;
      cyc(); tk_seen += frame_tick;
      frame_start = 1'b0;
      repeat (3) begin cyc(); tk_seen += frame_tick; end
    end
    check("serve_no_tick", tk_seen, 0);
    check("serve_to_play", state, 2);
    ball_x = 10'd100;
    frame_start = 1'b1;
    cyc(); check("tick_lat1", frame_tick, 0);
    cyc(); check("tick_lat2", frame_tick, 1);
    frame_start = 1'b0;
    cyc(); check("tick_width", frame_tick, 0);
    cyc();
    tk_seen = 0;
    frame_start = 1'b1;
    repeat (3) begin cyc(); tk_seen += frame_tick; end
    frame_start = 1'b0;
    repeat (3) begin cyc(); tk_seen += frame_tick; end
    check("wide_one_tick", tk_seen, 1);
    pulse(1);
    ball_x = 10'd6; ball_y = 10'd200; paddle_y = 10'd180;
    repeat (3) pulse(1);
    check("hit_once", score, 8'h01);
    ball_x = 10'd50;
    pulse(1);
    ball_x = 10'd6;
    pulse(1);
    check("hit_again", score, 8'h02);
    repeat (7) hit();
    check("score_09", score, 8'h09);
    hit();
    check("score_10", score, 8'h10);
    repeat (88) hit();
    check("score_98", score, 8'h98);
    hit();
    check("score_99", score, 8'h99);
    hit();
    check("score_sat", score, 8'h99);
    ball_x = 10'd100;
    pulse(1);
    ball_x = 10'd6; ball_y = 10'd300; paddle_y = 10'd100;
    pulse(1);
    check("miss_lives", lives, 1);
    check("miss_state", state, 3);
    ball_x = 10'd100;
    pulse(1);
    pulse(1);
    check("miss_to_serve", state, 1);
    pulse(1);
    pulse(1);
    check("serve2_play", state, 2);
    lose_life();
    check("over_state", state, 4);
    check("over_lives", lives, 0);
    check("over_score", score, 8'h99);
    press();
    check("new_state", state, 1);
    check("new_lives", lives, 2);
    check("new_score", score, 8'h00);
    pulse(1);
    pulse(1);
    press();
    check("sev_in_play", state, 2);
    frame_start = 1'b1;
    cyc();
    reset = 1'b1;
    cyc();
    check("midrst_state", state, 0);
    check("midrst_grst", game_reset, 1);
    check("midrst_tick", frame_tick, 0);
    reset = 1'b0;
    frame_start = 1'b0;
    cyc();
    press();
    pulse(1);
    pulse(1);
    lose_life();
    pulse(1);
    pulse(1);
    lose_life();
    check("over2_state", state, 4);
    frame_start = 1'b1;
    cyc();
    start_btn = 1'b1;
    cyc();
    check("sev_fev_state", state, 1);
    check("sev_fev_grst", game_reset, 1);
    start_btn = 1'b0;
    frame_start = 1'b0;
    repeat (3) cyc();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) frame_start = ~frame_start;
      start_btn = $urandom_range(0, 30) == 0;
      reset = $urandom_range(0, 500) == 0;
      if ($urandom_range(0, 7) == 0) begin
        ball_x = $urandom_range(0, 1) ? 10'($urandom_range(0, 12)) : 10'($urandom_range(0, 1023));
        ball_y = 10'($urandom_range(0, 1023));
        paddle_y = $urandom_range(0, 1) ? 10'(int'(ball_y) + $urandom_range(0, 80) - 70) : 10'($urandom_range(0, 1023));
      end
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
